// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot occupancy tracker.
// Gate direction FSM encoding, {outer,inner} sensor codes and a small popcount.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ENTER_OUTER = 3'd1,
    ENTER_BOTH  = 3'd2,
    ENTER_INNER = 3'd3,
    EXIT_INNER  = 3'd4,
    EXIT_BOTH   = 3'd5,
    EXIT_OUTER  = 3'd6
  } gate_state_t;

  // Filtered sensor pair, packed as {outer, inner}.
  localparam logic [1:0] SENSOR_NONE  = 2'b00;
  localparam logic [1:0] SENSOR_INNER = 2'b01;
  localparam logic [1:0] SENSOR_OUTER = 2'b10;
  localparam logic [1:0] SENSOR_BOTH  = 2'b11;

  // Number of set bits in up to eight per-gate pulses.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/parking_gate.sv
// One parking gate: 2-flop synchronisers and debounce filters on the outer and
// inner beams, followed by the 7-state direction FSM that classifies complete
// car passages into registered one-cycle enter/exit pulses.
// The FSM state is exposed on state_dbg.
module parking_gate
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        outer,
  input  logic        inner,
  output logic        enter_pulse,
  output logic        exit_pulse,
  output gate_state_t state_dbg
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      meta_q, meta_d;
  logic [1:0]      sync_q, sync_d;
  logic [1:0]      filt_q, filt_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];
  gate_state_t     state_q, state_d;
  logic            enter_q, enter_d;
  logic            exit_q, exit_d;

  // Synchroniser chain plus debounce: a bit is accepted once the synced value
  // has disagreed with the filtered value for DEBOUNCE_CYCLES straight cycles;
  // any cycle of agreement restarts the count.
  always_comb begin
    meta_d = {outer, inner};
    sync_d = meta_q;
    filt_d = filt_q;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (sync_q[b] != filt_q[b]) begin
        if (cnt_q[b] == DB_LAST) filt_d[b] = sync_q[b];
        else                     cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // Direction FSM on the filtered {outer,inner}; events only fire when both
  // beams clear after the car went through the matching *_BOTH state.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (filt_q == SENSOR_OUTER)      state_d = ENTER_OUTER;
        else if (filt_q == SENSOR_INNER) state_d = EXIT_INNER;
      end
      ENTER_OUTER: begin
        if (filt_q == SENSOR_BOTH)       state_d = ENTER_BOTH;
        else if (filt_q != SENSOR_OUTER) state_d = IDLE;
      end
      ENTER_BOTH: begin
        if (filt_q == SENSOR_INNER)      state_d = ENTER_INNER;
        else if (filt_q == SENSOR_OUTER) state_d = ENTER_OUTER;
        else if (filt_q == SENSOR_NONE)  state_d = IDLE;
      end
      ENTER_INNER: begin
        if (filt_q == SENSOR_NONE) begin
          state_d = IDLE;
          enter_d = 1'b1;
        end else if (filt_q == SENSOR_BOTH) begin
          state_d = ENTER_BOTH;
        end
      end
      EXIT_INNER: begin
        if (filt_q == SENSOR_BOTH)       state_d = EXIT_BOTH;
        else if (filt_q != SENSOR_INNER) state_d = IDLE;
      end
      EXIT_BOTH: begin
        if (filt_q == SENSOR_OUTER)      state_d = EXIT_OUTER;
        else if (filt_q == SENSOR_INNER) state_d = EXIT_INNER;
        else if (filt_q == SENSOR_NONE)  state_d = IDLE;
      end
      EXIT_OUTER: begin
        if (filt_q == SENSOR_NONE) begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end else if (filt_q == SENSOR_BOTH) begin
          state_d = EXIT_BOTH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All gate state; reset discards any passage in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      state_q  <= IDLE;
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      state_q  <= state_d;
      enter_q  <= enter_d;
      exit_q   <= exit_d;
    end
  end

  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign state_dbg   = state_q;

endmodule

// File: rtl/parking_lot_tracker.sv
// Multi-gate parking-lot occupancy tracker.
// NUM_GATES parking_gate instances feed one saturating occupancy counter with
// registered full/empty flags and sticky overflow/underflow flags.
// Optional macro PARKING_STATS_EN adds lifetime total_entries/total_exits.
// gate_state_dbg carries each gate's FSM state, 3 bits per gate.
module parking_lot_tracker
  import parking_pkg::*;
#(
  parameter  int NUM_GATES       = 2,
  parameter  int CAPACITY        = 15,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(CAPACITY + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_GATES-1:0]   outer,
  input  logic [NUM_GATES-1:0]   inner,
  input  logic                   clear,
  output logic [NUM_GATES-1:0]   enter_pulse,
  output logic [NUM_GATES-1:0]   exit_pulse,
`ifdef PARKING_STATS_EN
  output logic [15:0]            total_entries,
  output logic [15:0]            total_exits,
`endif
  output logic [CNT_W-1:0]       occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow_err,
  output logic                   underflow_err,
  output logic [3*NUM_GATES-1:0] gate_state_dbg
);

  localparam int NET_W = CNT_W + 2;
  localparam logic signed [NET_W-1:0] CAP_S = NET_W'(CAPACITY);
  localparam logic [CNT_W-1:0]        CAP_U = CNT_W'(CAPACITY);

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_state_t gate_st;
    parking_gate #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_gate (
      .clk        (clk),
      .reset_n    (reset_n),
      .outer      (outer[g]),
      .inner      (inner[g]),
      .enter_pulse(enter_pulse[g]),
      .exit_pulse (exit_pulse[g]),
      .state_dbg  (gate_st)
    );
    assign gate_state_dbg[3*g +: 3] = gate_st;
  end

  logic [3:0]              en_cnt, ex_cnt;
  logic signed [NET_W-1:0] net, sum;
  logic [CNT_W-1:0]        occ_q, occ_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  // Merge all gate pulses of this cycle into one signed step, clamp the sum
  // into 0..CAPACITY and latch errors; clear wins over accumulation.
  always_comb begin
    en_cnt  = popcount(8'(enter_pulse));
    ex_cnt  = popcount(8'(exit_pulse));
    net     = NET_W'(en_cnt) - NET_W'(ex_cnt);
    sum     = $signed({2'b00, occ_q}) + net;
    occ_d   = occ_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clear) begin
      occ_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (sum[NET_W-1]) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else if (sum > CAP_S) begin
      occ_d = CAP_U;
      ovf_d = 1'b1;
    end else begin
      occ_d = sum[CNT_W-1:0];
    end
    full_d  = (occ_d == CAP_U);
    empty_d = (occ_d == '0);
  end

  // Occupancy, flags and errors, registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign occupancy     = occ_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef PARKING_STATS_EN
  logic [15:0] tot_en_q, tot_en_d;
  logic [15:0] tot_ex_q, tot_ex_d;

  // Lifetime pulse totals, including clamped events; wrap naturally at 16 bits.
  always_comb begin
    tot_en_d = tot_en_q + 16'(en_cnt);
    tot_ex_d = tot_ex_q + 16'(ex_cnt);
  end

  // Totals survive clear; only reset_n zeroes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tot_en_q <= '0;
      tot_ex_q <= '0;
    end else begin
      tot_en_q <= tot_en_d;
      tot_ex_q <= tot_ex_d;
    end
  end

  assign total_entries = tot_en_q;
  assign total_exits   = tot_ex_q;
`endif

endmodule
